// File: rtl/wb_stage_if.sv
// Interface between the memory stage and the writeback stage.
// It carries the stage_regs bundle, the load word and all writeback results.
interface wb_stage_if #(
  parameter int unsigned CNT_W = 64
);
  typedef struct packed {
    logic       load_regfile;
    logic [3:0] regfilemux_sel;
    logic       read_b;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] br;
    logic [31:0] u_imm;
    logic [4:0]  rd;
    logic        valid;
    ctrl_t       ctrl;
  } stage_regs;

  stage_regs        regs_in;
  logic [31:0]      dcache_out;
  logic             advance;
  logic             load_regfile;
  logic [4:0]       rd_out;
  logic [31:0]      rd_data;
  logic [31:0]      wb_mem;
  logic [4:0]       wb_rd;
  logic             wb_fwd_valid;
  logic [4:0]       byp_rd;
  logic [31:0]      byp_data;
  logic             byp_valid;
  logic             misalign;
  logic [CNT_W-1:0] instret;

  modport slave (
    input  regs_in, dcache_out, advance,
    output load_regfile, rd_out, rd_data, wb_mem, wb_rd, wb_fwd_valid,
           byp_rd, byp_data, byp_valid, misalign, instret
  );

  modport master (
    output regs_in, dcache_out, advance,
    input  load_regfile, rd_out, rd_data, wb_mem, wb_rd, wb_fwd_valid,
           byp_rd, byp_data, byp_valid, misalign, instret
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: load alignment, writeback mux, single commit per instruction, bypass reg.
// Define WB_INSTRET_EN to build the retired-instruction counter.
module wb_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 64
) (
  input logic       clk,
  input logic       reset,
  wb_stage_if.slave wb
);
  logic            done_q, done_d;
  logic            commit;
  logic            wr_en;
  logic [XLEN-1:0] wb_val;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [4:0]      byp_rd_q, byp_rd_d;
  logic [XLEN-1:0] byp_data_q, byp_data_d;
  logic            byp_valid_q, byp_valid_d;
  logic            misalign;
  logic            unused_br;

  assign unused_br = ^wb.regs_in.br[31:1];

  assign ld_byte = wb.dcache_out[{wb.regs_in.alu[1:0], 3'b000} +: 8];
  assign ld_half = wb.dcache_out[{wb.regs_in.alu[1], 4'b0000} +: 16];

  always_comb begin
    wb_val = '0;
    case (wb.regs_in.ctrl.regfilemux_sel)
      4'd0:    wb_val = wb.regs_in.alu;
      4'd1:    wb_val = {31'b0, wb.regs_in.br[0]};
      4'd2:    wb_val = wb.regs_in.u_imm;
      4'd3:    wb_val = wb.dcache_out;
      4'd4:    wb_val = wb.regs_in.pc + 32'd4;
      4'd5:    wb_val = {{24{ld_byte[7]}}, ld_byte};
      4'd6:    wb_val = {24'b0, ld_byte};
      4'd7:    wb_val = {{16{ld_half[15]}}, ld_half};
      4'd8:    wb_val = {16'b0, ld_half};
      default: wb_val = '0;
    endcase
  end

  // done_q suppresses re-commit while the instruction sits in WB across stalls.
  assign commit = wb.regs_in.valid & ~done_q;
  assign wr_en  = commit & wb.regs_in.ctrl.load_regfile & (wb.regs_in.rd != 5'd0);

  always_comb begin
    misalign = 1'b0;
    if (commit && wb.regs_in.ctrl.read_b) begin
      case (wb.regs_in.ctrl.regfilemux_sel)
        4'd3:       misalign = (wb.regs_in.alu[1:0] != 2'b00);
        4'd7, 4'd8: misalign = wb.regs_in.alu[0];
        default:    misalign = 1'b0;
      endcase
    end
  end

  always_comb begin
    done_d      = done_q;
    byp_rd_d    = byp_rd_q;
    byp_data_d  = byp_data_q;
    byp_valid_d = byp_valid_q;
    if (wb.advance) begin
      done_d = 1'b0;
    end else if (commit) begin
      done_d = 1'b1;
    end
    if (wr_en) begin
      byp_rd_d    = wb.regs_in.rd;
      byp_data_d  = wb_val;
      byp_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_q      <= 1'b0;
      byp_rd_q    <= '0;
      byp_data_q  <= '0;
      byp_valid_q <= 1'b0;
    end else begin
      done_q      <= done_d;
      byp_rd_q    <= byp_rd_d;
      byp_data_q  <= byp_data_d;
      byp_valid_q <= byp_valid_d;
    end
  end

`ifdef WB_INSTRET_EN
  logic [CNT_W-1:0] instret_q, instret_d;

  // Counts every commit, including stores, branches and x0 writes.
  assign instret_d = commit ? instret_q + {{(CNT_W-1){1'b0}}, 1'b1} : instret_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign wb.instret = instret_q;
`else
  assign wb.instret = {CNT_W{1'b0}};
`endif

  assign wb.load_regfile = wr_en;
  assign wb.rd_out       = wb.regs_in.rd;
  assign wb.rd_data      = wb_val;
  assign wb.wb_mem       = wb_val;
  assign wb.wb_rd        = wb.regs_in.rd;
  assign wb.wb_fwd_valid = wb.regs_in.valid & wb.regs_in.ctrl.load_regfile &
                           (wb.regs_in.rd != 5'd0);
  assign wb.byp_rd       = byp_rd_q;
  assign wb.byp_data     = byp_data_q;
  assign wb.byp_valid    = byp_valid_q;
  assign wb.misalign     = misalign;
endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage (default build and WB_INSTRET_EN build).
module tb_wb_stage;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  wb_stage_if #(.CNT_W(64)) bus ();

  wb_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ir(input int n);
`ifdef WB_INSTRET_EN
    return 64'(n);
`else
    return 64'(n - n);
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [3:0] sel, input logic [4:0] rd,
                       input logic [31:0] alu, input logic lr, input logic rb);
    bus.regs_in                     = '0;
    bus.regs_in.valid               = valid;
    bus.regs_in.ctrl.regfilemux_sel = sel;
    bus.regs_in.rd                  = rd;
    bus.regs_in.alu                 = alu;
    bus.regs_in.ctrl.load_regfile   = lr;
    bus.regs_in.ctrl.read_b         = rb;
  endtask

  logic [3:0]  ld_sel [4] = '{4'd5, 4'd6, 4'd7, 4'd8};
  logic [31:0] ld_alu [4] = '{32'h3, 32'h1, 32'h2, 32'h0};
  logic [31:0] ld_exp [4] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01};

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    reset          = 1'b1;
    bus.regs_in    = '0;
    bus.dcache_out = 32'h80FF_7F01;
    bus.advance    = 1'b0;
    step();
    step();
    check("rst_load_regfile", 64'(bus.load_regfile), 64'd0);
    check("rst_byp_valid", 64'(bus.byp_valid), 64'd0);
    check("rst_byp_rd", 64'(bus.byp_rd), 64'd0);
    check("rst_byp_data", 64'(bus.byp_data), 64'd0);
    check("rst_instret", bus.instret, 64'd0);
    check("rst_misalign", 64'(bus.misalign), 64'd0);
    check("rst_wb_mem", 64'(bus.wb_mem), 64'd0);
    reset = 1'b0;

    // ALU op
    drive(1'b1, 4'd0, 5'd5, 32'h1234_5678, 1'b1, 1'b0);
    bus.advance = 1'b1;
    #1;
    check("alu_load_regfile", 64'(bus.load_regfile), 64'd1);
    check("alu_rd_out", 64'(bus.rd_out), 64'd5);
    check("alu_rd_data", 64'(bus.rd_data), 64'h1234_5678);
    check("alu_fwd_valid", 64'(bus.wb_fwd_valid), 64'd1);
    step();
    check("alu_byp_rd", 64'(bus.byp_rd), 64'd5);
    check("alu_byp_data", 64'(bus.byp_data), 64'h1234_5678);
    check("alu_byp_valid", 64'(bus.byp_valid), 64'd1);
    check("alu_instret", bus.instret, ir(1));

    // Aligned loads, one per cycle
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ld_sel[i], 5'd8, ld_alu[i], 1'b1, 1'b1);
      #1;
      check($sformatf("load%0d_rd_data", i), 64'(bus.rd_data), 64'(ld_exp[i]));
      check($sformatf("load%0d_wr", i), 64'(bus.load_regfile), 64'd1);
      check($sformatf("load%0d_misalign", i), 64'(bus.misalign), 64'd0);
      step();
    end
    check("loads_instret", bus.instret, ir(5));

    // Stall hold: lw held for 4 cycles commits once
    drive(1'b1, 4'd3, 5'd7, 32'h0, 1'b1, 1'b1);
    bus.advance = 1'b0;
    #1;
    check("hold_c1_wr", 64'(bus.load_regfile), 64'd1);
    check("hold_c1_data", 64'(bus.rd_data), 64'h80FF_7F01);
    for (int c = 2; c <= 4; c++) begin
      step();
      if (c == 4) bus.advance = 1'b1;
      #1;
      check($sformatf("hold_c%0d_wr", c), 64'(bus.load_regfile), 64'd0);
    end
    check("hold_instret", bus.instret, ir(6));
    check("hold_byp_rd", 64'(bus.byp_rd), 64'd7);
    step();
    drive(1'b1, 4'd2, 5'd9, 32'h0, 1'b1, 1'b0);
    bus.regs_in.u_imm = 32'hABCD_0000;
    #1;
    check("after_hold_wr", 64'(bus.load_regfile), 64'd1);
    check("after_hold_data", 64'(bus.rd_data), 64'hABCD_0000);
    step();
    check("after_hold_byp_rd", 64'(bus.byp_rd), 64'd9);

    // x0 write
    drive(1'b1, 4'd0, 5'd0, 32'h55, 1'b1, 1'b0);
    #1;
    check("x0_wr", 64'(bus.load_regfile), 64'd0);
    check("x0_fwd_valid", 64'(bus.wb_fwd_valid), 64'd0);
    step();
    check("x0_instret", bus.instret, ir(8));
    check("x0_byp_rd", 64'(bus.byp_rd), 64'd9);

    // Bubble
    drive(1'b0, 4'd0, 5'd3, 32'h66, 1'b1, 1'b0);
    #1;
    check("bubble_wr", 64'(bus.load_regfile), 64'd0);
    check("bubble_fwd_valid", 64'(bus.wb_fwd_valid), 64'd0);
    step();
    check("bubble_instret", bus.instret, ir(8));
    check("bubble_byp_data", 64'(bus.byp_data), 64'hABCD_0000);

    // Misaligned lw
    drive(1'b1, 4'd3, 5'd4, 32'h2, 1'b1, 1'b1);
    #1;
    check("mis_pulse", 64'(bus.misalign), 64'd1);
    check("mis_rd_data", 64'(bus.rd_data), 64'h80FF_7F01);
    check("mis_wr", 64'(bus.load_regfile), 64'd1);
    step();
    drive(1'b0, 4'd0, 5'd0, 32'h0, 1'b0, 1'b0);
    #1;
    check("mis_end", 64'(bus.misalign), 64'd0);
    check("mis_instret", bus.instret, ir(9));

    // Misaligned lh (alu[0]=1)
    drive(1'b1, 4'd7, 5'd4, 32'h1, 1'b1, 1'b1);
    #1;
    check("mis_lh_pulse", 64'(bus.misalign), 64'd1);
    check("mis_lh_data", 64'(bus.rd_data), 64'h0000_7F01);
    step();

    // Reset during a stalled, already-committed instruction
    drive(1'b1, 4'd3, 5'd6, 32'h0, 1'b1, 1'b1);
    bus.advance = 1'b0;
    #1;
    check("rh_wr", 64'(bus.load_regfile), 64'd1);
    step();
    check("rh_byp_rd", 64'(bus.byp_rd), 64'd6);
    step();
    reset = 1'b1;
    step();
    check("rh_byp_valid", 64'(bus.byp_valid), 64'd0);
    check("rh_byp_rd_clr", 64'(bus.byp_rd), 64'd0);
    check("rh_instret", bus.instret, 64'd0);
    bus.regs_in = '0;
    #1;
    check("rh_wr_clr", 64'(bus.load_regfile), 64'd0);
    step();
    reset = 1'b0;
    drive(1'b1, 4'd4, 5'd10, 32'h0, 1'b1, 1'b0);
    bus.regs_in.pc = 32'hFFFF_FFFC;
    #1;
    check("pc4_wr", 64'(bus.load_regfile), 64'd1);
    check("pc4_data", 64'(bus.rd_data), 64'h0);
    step();
    check("pc4_once", 64'(bus.load_regfile), 64'd0);
    check("pc4_byp_rd", 64'(bus.byp_rd), 64'd10);
    check("pc4_instret", bus.instret, ir(1));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage, directly downstream of the memory stage.
- Consumes the memory stage's stage_regs output and its registered dcache read data.
- Aligns and sign/zero-extends load data, selects the register-file write value, and issues exactly one register-file write per retired instruction.
- Exports the committed value for forwarding to EX/MEM and for ID read-during-write bypass; optionally counts retired instructions.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- CNT_W, 64, retired-instruction counter width; used only when WB_INSTRET_EN is defined.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- regs_in  input  $bits(stage_regs)  stage_regs from the memory stage; fields used: pc, alu, rd, br, u_imm, valid, ctrl.load_regfile, ctrl.regfilemux_sel (4 bits), ctrl.read_b.
- dcache_out  input  32  registered load word from the memory stage.
- advance  input  1  the memory-stage register loads this cycle (resp_a & ~stall); a new instruction appears in regs_in next cycle.
- load_regfile  output  1  register-file write enable.
- rd_out  output  5  register-file write index.
- rd_data  output  32  register-file write data.
- wb_mem  output  32  selected writeback value (combinational) for forwarding.
- wb_rd  output  5  destination of the instruction currently in WB.
- wb_fwd_valid  output  1  wb_mem is forwardable: regs_in.valid & ctrl.load_regfile & rd!=0.
- byp_rd  output  5  rd of the last committed write (registered).
- byp_data  output  32  data of the last committed write (registered).
- byp_valid  output  1  byp_rd/byp_data are valid.
- misalign  output  1  one-cycle pulse on commit of a misaligned load.
- instret  output  CNT_W  retired-instruction count.

Behaviour:
- Mux select (regfilemux_sel):
  - 0: alu.
  - 1: zext(br[0]).
  - 2: u_imm.
  - 3: lw, which is dcache_out.
  - 4: pc+4, mod 2^32.
  - 5: lb; 6: lbu.
  - 7: lh; 8: lhu.
  - 9-15: drive 0.
- Load alignment:
  - Bytes: select dcache_out[8*alu[1:0] +: 8].
  - Halves: select dcache_out[16*alu[1] +: 16]; alu[0] is ignored.
  - Words: alu[1:0] is ignored.
  - lb/lh sign-extend; lbu/lhu zero-extend.
- Commit:
  - commit = regs_in.valid & ~done_q.
  - done_q: set on commit; cleared when advance=1, which has priority over set in the same cycle; reset value 0.
  - Consequence: an instruction held in WB across memory-stage stalls commits exactly once, in its first cycle.
- Register-file write:
  - load_regfile = commit & ctrl.load_regfile & (rd!=0).
  - rd_out = rd, rd_data = the mux value.
  - All combinational in the commit cycle.
  - A write to x0 never asserts load_regfile.
- Bypass register:
  - On a cycle with load_regfile=1, byp_rd/byp_data/byp_valid load rd/rd_data/1.
  - Otherwise they hold.
  - Reset: 0/0/0.
- misalign:
  - Asserts when commit & ctrl.read_b and either lh/lhu with alu[0]=1 or lw with alu[1:0]!=0.
  - The write still occurs, using the alignment rules above.
- Reset mid-operation: done_q, byp_*, and instret clear in the same cycle; combinational outputs follow regs_in (regs_in is itself cleared by the memory-stage reset).
- Output reset values: load_regfile=0, byp_valid=0, byp_rd=0, byp_data=0, instret=0, misalign=0; wb_mem/wb_rd reflect the cleared regs_in (0).
- Invalid bubbles (valid=0) never commit, never count, and never write.

Optional Feature:
- Macro: WB_INSTRET_EN.
- Defined:
  - instret is a CNT_W-bit counter, +1 on every commit (including stores, branches, and x0 writes).
  - Wraps from all-ones to 0.
  - Synchronous reset to 0.
- Undefined: instret is tied to 0 and no counter flops are inferred.

Test Plan:
- ALU op: valid, sel=0, alu=0x1234_5678, rd=5, advance every cycle -> load_regfile=1 for one cycle, rd_out=5, rd_data=0x12345678; next cycle byp_rd=5, byp_data=0x12345678, byp_valid=1.
- Loads with dcache_out=0x80FF_7F01:
  - lb, alu=...3 -> 0xFFFFFF80.
  - lbu, alu=...1 -> 0x0000007F.
  - lh, alu=...2 -> 0xFFFF80FF.
  - lhu, alu=...0 -> 0x00007F01.
- Stall hold: same valid lw held with advance=0 for 4 cycles -> load_regfile high only in cycle 1; instret +1 total; next instruction after advance commits normally.
- x0 and bubble:
  - rd=0 with load_regfile ctrl set -> load_regfile stays 0 and wb_fwd_valid=0; instret still +1 with WB_INSTRET_EN defined.
  - valid=0 -> no write and no count.
- Misaligned lw at alu=0x...2 -> misalign pulses 1 cycle; rd_data=0x80FF7F01.
- Reset mid-hold: assert reset during a stalled committed instruction -> byp_valid=0 and instret=0 next cycle; after release, a new valid instruction commits once; pc=0xFFFF_FFFC with sel=4 -> rd_data=0x00000000.
